// File: rtl/uart_echo_tester.sv
// UART echo tester: sends an incrementing byte stream out tx and
// scores the echoes coming back on rx.
module uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_in,
    output logic       rdy,
    output logic       tx
);
    localparam logic [15:0] CPB_M1 = 16'(CLK_FREQ / BAUD - 1);

    logic [9:0]  r_shift;
    logic [3:0]  r_bits;
    logic [15:0] r_baud;
    logic        r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '1;
            r_bits  <= '0;
            r_baud  <= '0;
            r_busy  <= 1'b0;
        end else if (!r_busy) begin
            if (en) begin
                r_shift <= {1'b1, data_in, 1'b0};
                r_bits  <= 4'd10;
                r_baud  <= CPB_M1;
                r_busy  <= 1'b1;
            end
        end else if (r_baud == 16'd0) begin
            // shift in ones so the line rests high once the frame is out
            r_shift <= {1'b1, r_shift[9:1]};
            r_baud  <= CPB_M1;
            r_bits  <= r_bits - 4'd1;
            if (r_bits == 4'd1) r_busy <= 1'b0;
        end else begin
            r_baud <= r_baud - 16'd1;
        end
    end

    assign rdy = !r_busy;
    assign tx  = r_shift[0];
endmodule

module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       data_ready,
    output logic [7:0] data
);
    localparam logic [15:0] CPB_M1 = 16'(CLK_FREQ / BAUD - 1);
    localparam logic [15:0] HALF   = 16'(CLK_FREQ / BAUD / 2 - 1);

    logic [1:0]  r_sync;
    logic        r_active;
    logic [15:0] r_baud;
    logic [3:0]  r_bits;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bits   <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_ready <= 1'b0;
            if (!r_active) begin
                if (!r_sync[1]) begin
                    r_active <= 1'b1;
                    r_baud   <= HALF;
                    r_bits   <= 4'd0;
                end
            end else if (r_baud != 16'd0) begin
                r_baud <= r_baud - 16'd1;
            end else begin
                r_baud <= CPB_M1;
                if (r_bits == 4'd0) begin
                    // a start bit that is gone by mid-bit was a glitch
                    if (r_sync[1]) r_active <= 1'b0;
                    else r_bits <= 4'd1;
                end else if (r_bits < 4'd9) begin
                    r_shift <= {r_sync[1], r_shift[7:1]};
                    r_bits  <= r_bits + 4'd1;
                end else begin
                    r_active <= 1'b0;
                    r_ready  <= r_sync[1];
                    r_data   <= r_shift;
                end
            end
        end
    end

    assign data_ready = r_ready;
    assign data       = r_data;
endmodule

module uart_echo_tester #(
    parameter int BAUD     = 9600,
    parameter int N_BYTES  = 256,
    parameter int TIMEOUT  = 100000,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] err_count,
    output logic [15:0] timeout_count,
    output logic [3:0]  leds
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ECHO, DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_pass, r_err, r_tmo_cnt, r_index;
    logic [7:0]  r_expect;
    logic [31:0] r_timer;
    logic [3:0]  r_leds;
    logic        w_tx_en, w_tx_rdy, w_rx_ready, w_clear;
    logic        w_advance, w_expire, w_in_wait;
    logic [7:0]  w_rx_data;

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .clk(clk), .rst(rst), .en(w_tx_en), .data_in(r_expect),
        .rdy(w_tx_rdy), .tx(tx)
    );

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk(clk), .rst(rst), .rx(rx),
        .data_ready(w_rx_ready), .data(w_rx_data)
    );

    assign w_in_wait = (r_state == WAIT_ECHO);
    assign w_expire  = w_in_wait && (r_timer <= 32'd1);
    assign w_advance = w_in_wait && (w_rx_ready || w_expire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_tx_en = 1'b0;
        w_clear = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next  = SEND;
                    w_clear = 1'b1;
                end
            end
            SEND: begin
                if (w_tx_rdy) begin
                    w_tx_en = 1'b1;
                    w_next  = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                if (w_advance)
                    w_next = (r_index == 16'(N_BYTES - 1)) ? DONE : SEND;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass    <= '0;
            r_err     <= '0;
            r_tmo_cnt <= '0;
            r_index   <= '0;
            r_expect  <= '0;
            r_timer   <= '0;
        end else if (w_clear) begin
            r_pass    <= '0;
            r_err     <= '0;
            r_tmo_cnt <= '0;
            r_index   <= '0;
            r_expect  <= '0;
        end else begin
            if (w_tx_en) r_timer <= 32'(TIMEOUT);
            else if (w_in_wait && r_timer != 32'd0) r_timer <= r_timer - 32'd1;
            // a byte landing on the expiry cycle still counts as received
            if (w_rx_ready) begin
                if (w_in_wait && w_rx_data == r_expect) begin
                    if (r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
                end else if (r_err != 16'hFFFF) begin
                    r_err <= r_err + 16'd1;
                end
            end else if (w_expire && r_tmo_cnt != 16'hFFFF) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            if (w_advance) begin
                r_expect <= r_expect + 8'd1;
                r_index  <= r_index + 16'd1;
            end
        end
    end

    assign busy = (r_state == SEND) || (r_state == WAIT_ECHO);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_leds <= 4'b0000;
        else     r_leds <= {r_err != 16'd0, r_tmo_cnt != 16'd0, busy, done};
    end

    assign pass_count    = r_pass;
    assign err_count     = r_err;
    assign timeout_count = r_tmo_cnt;
    assign leds          = r_leds;
endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: loopback, corrupting echo,
// silent line, unsolicited byte, mid-run reset and index wrap.
module tb_uart_echo_tester;
    localparam int CPB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, start_c;
    logic        tx_a, rx_a, busy_a, done_a;
    logic        tx_b, rx_b, busy_b, done_b;
    logic        tx_c, rx_c, busy_c, done_c;
    logic [15:0] pass_a, err_a, tmo_a, pass_b, err_b, tmo_b;
    logic [15:0] pass_c, err_c, tmo_c;
    logic [3:0]  leds_a, leds_b, leds_c;

    int          mode_a;
    logic        rx_a_drv;
    int          mon_sel;
    logic        tx_mon;
    logic [7:0]  mon_q[$];
    logic [7:0]  echo_q[$];
    int          checks = 0;
    int          failures = 0;

    assign rx_a   = (mode_a == 0) ? tx_a : rx_a_drv;
    assign rx_b   = 1'b1;
    assign rx_c   = tx_c;
    assign tx_mon = (mon_sel == 0) ? tx_a : tx_c;

    uart_echo_tester #(.BAUD(100_000), .N_BYTES(4), .TIMEOUT(400),
                       .CLK_FREQ(800_000)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .rx(rx_a), .tx(tx_a),
        .busy(busy_a), .done(done_a), .pass_count(pass_a),
        .err_count(err_a), .timeout_count(tmo_a), .leds(leds_a));

    uart_echo_tester #(.BAUD(100_000), .N_BYTES(2), .TIMEOUT(1000),
                       .CLK_FREQ(800_000)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .rx(rx_b), .tx(tx_b),
        .busy(busy_b), .done(done_b), .pass_count(pass_b),
        .err_count(err_b), .timeout_count(tmo_b), .leds(leds_b));

    uart_echo_tester #(.BAUD(100_000), .N_BYTES(258), .TIMEOUT(400),
                       .CLK_FREQ(800_000)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .rx(rx_c), .tx(tx_c),
        .busy(busy_c), .done(done_c), .pass_count(pass_c),
        .err_count(err_c), .timeout_count(tmo_c), .leds(leds_c));

    // Line monitor decoding frames on the selected tx
    always begin
        logic [7:0] b;
        b = 8'h00;
        @(negedge tx_mon);
        repeat (CPB / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            b = {tx_mon, b[7:1]};
        end
        repeat (CPB) @(posedge clk);
        mon_q.push_back(b);
        if (mode_a == 1 && mon_sel == 0)
            echo_q.push_back((b == 8'h02) ? (b ^ 8'h80) : b);
    end

    task automatic send_a(input logic [7:0] b);
        @(negedge clk);
        rx_a_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_a_drv = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    always begin
        logic [7:0] e;
        while (echo_q.size() == 0) @(posedge clk);
        e = echo_q.pop_front();
        send_a(e);
    end

    task automatic test_reset;
        if (busy_a !== 1'b0) begin failures++;
            $display("FAIL reset_busy got %b exp 0", busy_a); end
        checks++;
        if (done_a !== 1'b0) begin failures++;
            $display("FAIL reset_done got %b exp 0", done_a); end
        checks++;
        if ({pass_a, err_a, tmo_a} !== 48'd0) begin failures++;
            $display("FAIL reset_counts got %h exp 0", {pass_a, err_a, tmo_a}); end
        checks++;
        if (leds_a !== 4'b0000) begin failures++;
            $display("FAIL reset_leds got %b exp 0000", leds_a); end
        checks++;
        if (tx_a !== 1'b1) begin failures++;
            $display("FAIL reset_tx got %b exp 1", tx_a); end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done_a(input int limit, input string name);
        int n;
        n = 0;
        while (done_a !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_a !== 1'b1) begin failures++;
            $display("FAIL %s_timeout got done=%b exp 1", name, done_a); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback;
        mode_a = 0;
        mon_sel = 0;
        mon_q.delete();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0) begin failures++;
            $display("FAIL loop_busy got %b%b exp 10", busy_a, done_a); end
        wait_done_a(3000, "loop");
        checks++;
        if (pass_a !== 16'd4) begin failures++;
            $display("FAIL loop_pass got %0d exp 4", pass_a); end
        checks++;
        if (err_a !== 16'd0 || tmo_a !== 16'd0) begin failures++;
            $display("FAIL loop_err got %0d/%0d exp 0/0", err_a, tmo_a); end
        checks++;
        if (leds_a !== 4'b0001) begin failures++;
            $display("FAIL loop_leds got %b exp 0001", leds_a); end
        checks++;
        if (mon_q.size() != 4) begin failures++;
            $display("FAIL loop_nbytes got %0d exp 4", mon_q.size()); end
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== 8'(i)) begin failures++;
                $display("FAIL loop_byte%0d got %h exp %h", i, mon_q[i], 8'(i)); end
        end
    endtask

    task automatic test_restart_xor;
        mode_a = 1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (250) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        wait_done_a(4000, "xor");
        checks++;
        if (pass_a !== 16'd3) begin failures++;
            $display("FAIL xor_pass got %0d exp 3", pass_a); end
        checks++;
        if (err_a !== 16'd1) begin failures++;
            $display("FAIL xor_err got %0d exp 1", err_a); end
        checks++;
        if (tmo_a !== 16'd0) begin failures++;
            $display("FAIL xor_tmo got %0d exp 0", tmo_a); end
        checks++;
        if (leds_a !== 4'b1001) begin failures++;
            $display("FAIL xor_leds got %b exp 1001", leds_a); end
        repeat (20) @(negedge clk);
        mode_a = 0;
    endtask

    task automatic test_unsolicited;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mode_a = 2;
        send_a(8'h55);
        repeat (10) @(negedge clk);
        checks++;
        if (err_a !== 16'd1) begin failures++;
            $display("FAIL unsol_err got %0d exp 1", err_a); end
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 16'd0) begin
            failures++;
            $display("FAIL unsol_state got b%b d%b p%0d exp 0 0 0",
                     busy_a, done_a, pass_a); end
        checks++;
        if (leds_a !== 4'b1000) begin failures++;
            $display("FAIL unsol_leds got %b exp 1000", leds_a); end
        mode_a = 0;
    endtask

    task automatic test_reset_midrun;
        int n;
        mode_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 0;
        while (pass_a !== 16'd1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pass_a !== 16'd1) begin failures++;
            $display("FAIL mid_first got %0d exp 1", pass_a); end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || tx_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_abort got b%b d%b tx%b exp 0 0 1",
                     busy_a, done_a, tx_a); end
        checks++;
        if ({pass_a, err_a, tmo_a} !== 48'd0 || leds_a !== 4'b0000) begin
            failures++;
            $display("FAIL mid_clear got %h/%b exp 0/0000",
                     {pass_a, err_a, tmo_a}, leds_a); end
        @(negedge clk) rst = 1'b0;
        repeat (200) @(negedge clk);
        mon_q.delete();
        checks++;
        if (busy_a !== 1'b0 || err_a !== 16'd0) begin failures++;
            $display("FAIL mid_idle got b%b e%0d exp 0 0", busy_a, err_a); end
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        wait_done_a(3000, "mid_rerun");
        checks++;
        if (pass_a !== 16'd4 || err_a !== 16'd0) begin failures++;
            $display("FAIL mid_rerun got p%0d e%0d exp 4 0", pass_a, err_a); end
    endtask

    task automatic test_timeout;
        int n;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_b !== 1'b1) begin failures++;
            $display("FAIL tmo_done got %b exp 1", done_b); end
        checks++;
        if (n < 1990 || n > 2020) begin failures++;
            $display("FAIL tmo_cycles got %0d exp 1990..2020", n); end
        repeat (2) @(negedge clk);
        checks++;
        if (tmo_b !== 16'd2) begin failures++;
            $display("FAIL tmo_count got %0d exp 2", tmo_b); end
        checks++;
        if (pass_b !== 16'd0 || err_b !== 16'd0) begin failures++;
            $display("FAIL tmo_other got p%0d e%0d exp 0 0", pass_b, err_b); end
        checks++;
        if (leds_b !== 4'b0101) begin failures++;
            $display("FAIL tmo_leds got %b exp 0101", leds_b); end
    endtask

    task automatic test_wrap;
        int n;
        mon_sel = 1;
        mon_q.delete();
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        n = 0;
        while (done_c !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_c !== 1'b1) begin failures++;
            $display("FAIL wrap_done got %b exp 1", done_c); end
        repeat (2) @(negedge clk);
        checks++;
        if (pass_c !== 16'd258) begin failures++;
            $display("FAIL wrap_pass got %0d exp 258", pass_c); end
        checks++;
        if (err_c !== 16'd0 || tmo_c !== 16'd0) begin failures++;
            $display("FAIL wrap_err got e%0d t%0d exp 0 0", err_c, tmo_c); end
        checks++;
        if (mon_q.size() != 258) begin failures++;
            $display("FAIL wrap_nbytes got %0d exp 258", mon_q.size()); end
        if (mon_q.size() == 258) begin
            checks++;
            if ({mon_q[254], mon_q[255], mon_q[256], mon_q[257]} !== 32'hFEFF0001)
            begin failures++;
                $display("FAIL wrap_seq got %h%h%h%h exp FEFF0001",
                         mon_q[254], mon_q[255], mon_q[256], mon_q[257]); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        mode_a   = 0;
        rx_a_drv = 1'b1;
        mon_sel  = 0;
        repeat (5) @(negedge clk);
        test_reset();
        test_loopback();
        test_restart_xor();
        test_unsolicited();
        test_reset_midrun();
        test_timeout();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
